// File: rtl/dmem_pkg.sv
// Shared encodings for the sized data memory: access sizes, FSM states, lane width.
package dmem_pkg;

  localparam int unsigned LANE_W = 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    ST_INIT = 2'b00,
    ST_IDLE = 2'b01,
    ST_WAIT = 2'b10,
    ST_RESP = 2'b11
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte-enables/merge, load extract/extend, misalign flag.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_t       size,
  input  logic [1:0]  lane,
  input  logic        zext,
  input  logic [31:0] wdata,
  input  logic [31:0] cur_word,
  output logic [3:0]  be,
  output logic [31:0] st_word,
  output logic [31:0] ld_word,
  output logic        misalign
);

  logic [31:0]       rep;
  logic [LANE_W-1:0] byte_sel;
  logic [15:0]       half_sel;

  always_comb begin
    be       = '0;
    rep      = wdata;
    ld_word  = '0;
    misalign = 1'b0;
    byte_sel = cur_word[{lane, 3'b000} +: LANE_W];
    half_sel = lane[1] ? cur_word[31:16] : cur_word[15:0];
    case (size)
      SZ_BYTE: begin
        be      = 4'b0001 << lane;
        rep     = {4{wdata[7:0]}};
        ld_word = zext ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        be       = lane[1] ? 4'b1100 : 4'b0011;
        rep      = {2{wdata[15:0]}};
        misalign = lane[0];
        ld_word  = zext ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      SZ_WORD: begin
        be       = 4'b1111;
        misalign = (lane != 2'b00);
        ld_word  = cur_word;
      end
      default: ;
    endcase
    // Replicated store data lands in every lane; byte-enables pick which survive.
    for (int i = 0; i < 4; i++) begin
      st_word[i*LANE_W +: LANE_W] = be[i] ? rep[i*LANE_W +: LANE_W]
                                          : cur_word[i*LANE_W +: LANE_W];
    end
  end

endmodule

// File: rtl/dmem_sized.sv
// Byte-addressed sized data memory with self-init, wait-state latency and fault reporting.
module dmem_sized
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned LATENCY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic              init_done
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned WAIT_W = 4;
  localparam int unsigned WIDX_W = ADDR_W - 2;

  state_t            state, state_n;
  logic [IDX_W-1:0]  init_cnt, init_cnt_n;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_n;

  logic              cap_write;
  size_t             cap_size;
  logic              cap_uns;
  logic [ADDR_W-1:0] cap_addr;
  logic [31:0]       cap_wdata;

  logic [31:0]       mem [DEPTH];

  logic [WIDX_W-1:0] widx;
  logic              in_range;
  logic [31:0]       cur_word;
  logic [3:0]        be;
  logic [31:0]       st_word;
  logic [31:0]       ld_word;
  logic              misalign;
  logic              fault;
  logic              access;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [31:0]       mem_wdata;

  assign widx     = cap_addr[ADDR_W-1:2];
  assign in_range = {1'b0, widx} < (WIDX_W+1)'(DEPTH);
  assign cur_word = mem[widx[IDX_W-1:0]];
  assign fault    = (cap_size == SZ_RSVD) || misalign || !in_range;
  assign access   = (state == ST_WAIT) && (wait_cnt == '0);

  dmem_lane_align u_align (
    .size     (cap_size),
    .lane     (cap_addr[1:0]),
    .zext     (cap_uns),
    .wdata    (cap_wdata),
    .cur_word (cur_word),
    .be       (be),
    .st_word  (st_word),
    .ld_word  (ld_word),
    .misalign (misalign)
  );

  // State register and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      init_cnt <= init_cnt_n;
      wait_cnt <= wait_cnt_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n    = state;
    init_cnt_n = init_cnt;
    wait_cnt_n = wait_cnt;
    case (state)
      ST_INIT: begin
        init_cnt_n = init_cnt + IDX_W'(1);
        if (init_cnt == IDX_W'(DEPTH - 1)) state_n = ST_IDLE;
      end
      ST_IDLE: begin
        if (req_valid) begin
          state_n    = ST_WAIT;
          wait_cnt_n = WAIT_W'(LATENCY);
        end
      end
      ST_WAIT: begin
        if (wait_cnt == '0) state_n = ST_RESP;
        else                wait_cnt_n = wait_cnt - WAIT_W'(1);
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_INIT;
    endcase
  end

  // Request capture on the acceptance edge only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_write <= 1'b0;
      cap_size  <= SZ_BYTE;
      cap_uns   <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (state == ST_IDLE && req_valid) begin
      cap_write <= req_write;
      cap_size  <= size_t'(req_size);
      cap_uns   <= req_unsigned;
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      req_ready  <= (state_n == ST_IDLE);
      resp_valid <= access;
      resp_fault <= access && fault;
      resp_rdata <= (access && !fault && !cap_write) ? ld_word : '0;
      init_done  <= init_done || (state == ST_INIT && state_n == ST_IDLE);
    end
  end

  // Memory write port; gated by rst so an in-flight store is dropped
  assign mem_we    = !rst && ((state == ST_INIT) || (access && cap_write && !fault));
  assign mem_widx  = (state == ST_INIT) ? init_cnt : widx[IDX_W-1:0];
  assign mem_wdata = (state == ST_INIT) ? 32'(init_cnt) : st_word;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
  end

endmodule

// File: tb/tb_dmem_sized.sv
// Randomized self-checking bench for dmem_sized against a byte-array reference model.
module tb_dmem_sized;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned LAT    = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_fault;
  logic              init_done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] mem_m [DEPTH*4];

  dmem_sized #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_fault   (resp_fault),
    .init_done    (init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < int'(DEPTH); i++)
      for (int k = 0; k < 4; k++) mem_m[4*i+k] = 8'((i >> (8*k)) & 8'hff);
  endfunction

  // Returns {fault, rdata} and applies stores to the byte array.
  function automatic logic [32:0] model_access(input logic w, input logic [1:0] sz,
      input logic u, input int unsigned a, input logic [31:0] wd);
    int unsigned nb;
    logic [31:0] v;
    if (sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) || a / 4 >= DEPTH)
      return {1'b1, 32'h0};
    nb = 1 << sz;
    v  = '0;
    for (int unsigned k = 0; k < nb; k++) begin
      if (w) mem_m[a+k] = wd[8*k +: 8];
      else   v = v | (32'(mem_m[a+k]) << (8*k));
    end
    if (w) return 33'h0;
    if (!u && nb < 4 && v[8*nb-1]) v = v | ~((32'h1 << (8*nb)) - 32'h1);
    return {1'b0, v};
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic xact(input logic w, input logic [1:0] sz, input logic u,
      input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd, output logic flt);
    int n;
    logic [32:0] exp;
    wait_ready();
    req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    exp = model_access(w, sz, u, a, wd);
    @(posedge clk); #1;
    req_valid = 1'b0;
    // Scramble request fields during WAIT; they must be ignored.
    req_write = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 40);
    check("latency", 32'(n), 32'(LAT + 2));
    rd  = resp_rdata;
    flt = resp_fault;
    check("rdata", rd, exp[31:0]);
    check("fault", 32'(flt), 32'(exp[32]));
    @(negedge clk);
    check("ready_after", 32'(req_ready), 32'd1);
    check("resp_drop", {resp_valid, resp_rdata[30:0]}, 32'd0);
  endtask

  task automatic run_init();
    int n = 0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    while (!init_done && n < 200) begin @(posedge clk); #1; n++; end
    check("init_cycles", 32'(n), 32'(DEPTH));
    @(negedge clk);
  endtask

  logic [31:0] rd;
  logic        flt;
  int          t, acc0, acc1;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_outs", {28'h0, req_ready, resp_valid, resp_fault, init_done}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    run_init();

    xact(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, rd, flt);
    check("init_word5", rd, 32'h0000_0005);
    xact(1'b1, 2'd0, 1'b0, 32'h09, 32'h0000_00AB, rd, flt);
    xact(1'b0, 2'd2, 1'b0, 32'h08, 32'h0, rd, flt);
    check("byte_merge", rd, 32'h0000_AB02);
    xact(1'b0, 2'd0, 1'b0, 32'h09, 32'h0, rd, flt);
    check("byte_sext", rd, 32'hFFFF_FFAB);
    xact(1'b0, 2'd0, 1'b1, 32'h09, 32'h0, rd, flt);
    check("byte_zext", rd, 32'h0000_00AB);
    xact(1'b1, 2'd1, 1'b0, 32'h0E, 32'h0000_8001, rd, flt);
    xact(1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, rd, flt);
    check("half_merge", rd, 32'h8001_0003);
    xact(1'b0, 2'd1, 1'b0, 32'h0E, 32'h0, rd, flt);
    check("half_sext", rd, 32'hFFFF_8001);
    xact(1'b1, 2'd2, 1'b0, 32'h06, 32'h1234_5678, rd, flt);
    check("misalign_fault", 32'(flt), 32'd1);
    xact(1'b0, 2'd2, 1'b0, 32'h04, 32'h0, rd, flt);
    check("no_write_on_fault", rd, 32'h0000_0001);
    xact(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, rd, flt);
    check("range_fault", {flt, rd[30:0]}, 32'h8000_0000);
    xact(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, rd, flt);
    check("rsvd_fault", 32'(flt), 32'd1);

    // Back-to-back: valid held high, acceptances spaced LAT+3 cycles apart.
    wait_ready();
    req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h14;
    req_valid = 1'b1;
    acc0 = -1; acc1 = -1;
    for (t = 0; t < 3*int'(LAT) + 12 && acc1 < 0; t++) begin
      if (req_ready) begin
        if (acc0 < 0) acc0 = t; else acc1 = t;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("b2b_spacing", 32'(acc1 - acc0), 32'(LAT + 3));

    // Reset during WAIT drops the store and restarts init.
    wait_ready();
    req_write = 1'b1; req_size = 2'd2; req_addr = 32'h0; req_wdata = 32'hDEAD_BEEF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (LAT + 4) begin
      @(negedge clk);
      check("rst_wait_quiet", {30'h0, resp_valid, req_ready}, 32'd0);
    end
    run_init();
    xact(1'b0, 2'd2, 1'b0, 32'h00, 32'h0, rd, flt);
    check("rst_drop_store", rd, 32'h0000_0000);

    // Random mix of sizes, directions, alignments and out-of-range addresses.
    for (int i = 0; i < 200; i++) begin
      xact(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
           32'($urandom_range(0, DEPTH*4 + 31)), $urandom, rd, flt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
